// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Purpose  : Round-robin arbiter sharing one resource among 8 requesters.
//            Grants are held until done, a request drop, or a hold limit.
//            A new winner is chosen on the same edge as a release, so there
//            is no idle bubble between back-to-back grants.
// Ports    : clk         - rising-edge clock
//            rst         - asynchronous, active-high reset
//            req[7:0]    - level-sensitive request lines, bit i = requester i
//            done        - release strobe from the granted requester
//            grant[7:0]  - registered one-hot grant, zero when idle
//            grant_idx   - registered binary index of the granted requester
//            grant_valid - high while grant is non-zero
//            timeout     - one-cycle pulse after a hold-limit revocation
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   localparam logic [0:0] c_st_idle  = 1'b0;
   localparam logic [0:0] c_st_grant = 1'b1;

   // Last count value of a grant; the release fires on the edge that sees it,
   // which gives exactly MAX_HOLD cycles of grant.
   localparam logic [CNT_W-1:0] c_hold_last = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [CNT_W-1:0] c_hold_sat  = CNT_W'(MAX_HOLD);

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [7:0]       r_grant;
   logic [2:0]       r_idx;
   logic [2:0]       r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   logic [7:0]       w_grant_nxt;
   logic [2:0]       w_idx_nxt;
   logic [2:0]       w_ptr_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_timeout_nxt;

   logic [2:0]       w_winner;
   logic             w_any;
   logic             w_limit;
   logic             w_release;
   logic             w_limit_only;

   // ------------------------------------------------------------------------
   // Round-robin search: first set request scanning ptr+1 .. ptr+8 (mod 8).
   // The final candidate is ptr itself, so the current holder is re-granted
   // only when it is the sole requester still asserting.
   // ------------------------------------------------------------------------
   always_comb begin
      logic found;
      logic [2:0] cand;
      w_winner = 3'b000;
      found    = 1'b0;
      cand     = 3'b000;
      for (int k = 1; k <= 8; k++) begin
         cand = r_ptr + 3'(k);
         if (!found && req[cand]) begin
            w_winner = cand;
            found    = 1'b1;
         end
      end
   end

   assign w_any        = |req;
   assign w_limit      = (MAX_HOLD != 0) && (r_cnt == c_hold_last);
   assign w_release    = done || !req[r_idx] || w_limit;
   // Timeout only when the limit alone forced the release.
   assign w_limit_only = w_limit && !done && req[r_idx];

   // ------------------------------------------------------------------------
   // State register (also holds the registered outputs and datapath)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_st_idle;
         r_grant   <= 8'h00;
         r_idx     <= 3'b000;
         r_ptr     <= 3'b111;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_idx     <= w_idx_nxt;
         r_ptr     <= w_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  w_state_nxt = w_any ? c_st_grant : c_st_idle;
         c_st_grant: begin
            if (w_release && !w_any) begin
               w_state_nxt = c_st_idle;
            end
         end
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output / datapath next values
   // ------------------------------------------------------------------------
   always_comb begin
      w_grant_nxt   = r_grant;
      w_idx_nxt     = r_idx;
      w_ptr_nxt     = r_ptr;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (w_any) begin
               w_grant_nxt = 8'h01 << w_winner;
               w_idx_nxt   = w_winner;
               w_ptr_nxt   = w_winner;
               w_cnt_nxt   = '0;
            end
         end
         c_st_grant: begin
            if (w_release) begin
               w_timeout_nxt = w_limit_only;
               w_cnt_nxt     = '0;
               if (w_any) begin
                  w_grant_nxt = 8'h01 << w_winner;
                  w_idx_nxt   = w_winner;
                  w_ptr_nxt   = w_winner;
               end else begin
                  w_grant_nxt = 8'h00;
                  w_idx_nxt   = 3'b000;
               end
            end else if (r_cnt != c_hold_sat) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_grant_nxt = 8'h00;
            w_idx_nxt   = 3'b000;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign grant_valid = |r_grant;
   assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter8
// Purpose  : Directed self-checking bench for rr_arbiter8 (MAX_HOLD = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and sample 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected state given as one-hot grant plus timeout; idx/valid follow.
   task automatic chk_out(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                          input logic ev, input logic et);
      chk({tag, ".grant"}, grant, eg);
      chk({tag, ".idx"}, {5'b0, grant_idx}, {5'b0, ei});
      chk({tag, ".valid"}, {7'b0, grant_valid}, {7'b0, ev});
      chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, et});
   endtask

   initial begin
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      step();
      step();
      chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk_out("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

      // First grant, then asynchronous reset mid-grant.
      req = 8'h01;
      step();
      chk_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      req = 8'h00;
      step();
      rst = 1'b0;
      step();

      // All requesting, done every grant cycle: 0,1,...,7,0 back to back.
      req = 8'hFF;
      step();
      chk_out("rr_start", 8'h01, 3'd0, 1'b1, 1'b0);
      done = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_out($sformatf("rr_seq%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
      end
      done = 1'b0;
      req  = 8'h00;
      step();
      chk_out("rr_drop", 8'h00, 3'd0, 1'b0, 1'b0);

      // Set ptr to 5, then wrap to 0 and come back to 5.
      req = 8'h20;
      step();
      chk_out("ptr5", 8'h20, 3'd5, 1'b1, 1'b0);
      req  = 8'h21;
      done = 1'b1;
      step();
      chk_out("wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
      step();
      chk_out("back5", 8'h20, 3'd5, 1'b1, 1'b0);
      done = 1'b0;
      req  = 8'h00;
      step();
      chk_out("wrap_idle", 8'h00, 3'd0, 1'b0, 1'b0);

      // Hold limit: from ptr 5, req 0C grants 2 for 16 cycles, then 3.
      req = 8'h0C;
      step();
      chk_out("hold_c0", 8'h04, 3'd2, 1'b1, 1'b0);
      for (int k = 1; k <= 15; k++) begin
         if (k == 7) req = 8'hCC;   // non-granted bits change: no preemption
         step();
         chk_out($sformatf("hold_c%0d", k), 8'h04, 3'd2, 1'b1, 1'b0);
      end
      step();
      chk_out("timeout_hit", 8'h08, 3'd3, 1'b1, 1'b1);
      req = 8'h08;
      step();
      chk_out("timeout_once", 8'h08, 3'd3, 1'b1, 1'b0);
      req = 8'h00;
      step();
      chk_out("hold_idle", 8'h00, 3'd0, 1'b0, 1'b0);

      // Sole requester with done: continuous re-grant of 6, then drop.
      req  = 8'h40;
      done = 1'b1;
      step();
      chk_out("sole_g0", 8'h40, 3'd6, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_out($sformatf("sole_g%0d", k), 8'h40, 3'd6, 1'b1, 1'b0);
      end
      req  = 8'h00;
      done = 1'b0;
      step();
      chk_out("sole_drop", 8'h00, 3'd0, 1'b0, 1'b0);

      // done coincident with the last hold cycle: normal release, no timeout.
      req = 8'h0C;
      step();
      chk_out("coinc_g", 8'h04, 3'd2, 1'b1, 1'b0);
      for (int k = 1; k <= 15; k++) step();
      chk_out("coinc_last", 8'h04, 3'd2, 1'b1, 1'b0);
      done = 1'b1;
      step();
      chk_out("coinc_rel", 8'h08, 3'd3, 1'b1, 1'b0);
      done = 1'b0;
      req  = 8'h00;
      step();
      chk_out("coinc_idle", 8'h00, 3'd0, 1'b0, 1'b0);

      // done while idle is ignored; ptr stays 3 so req 80 wins 7.
      done = 1'b1;
      step();
      step();
      chk_out("idle_done", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0;
      req  = 8'h81;
      step();
      chk_out("after_idle_done", 8'h80, 3'd7, 1'b1, 1'b0);
      req = 8'h00;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
